l2_spi_slave_byte: RTL and testbench

SPI slave endpoint: the receiving end of the SCLK/CS_N/MOSI/MISO link driven by our SPI master clock/strobe generator.
- Oversamples the external SCLK, CS_N and MOSI in the system clock domain and recovers rise/fall strobes.
- Shifts MOSI in and MISO out per CPOL/CPHA, one DATA_WIDTH word at a time.
- Exposes a one-entry TX holding register (valid/ready) and a one-cycle RX word strobe to the slave-side user logic.

---
 rtl/l2_spi_pkg.sv | 30 +++
 rtl/l2_spi_sync_edge.sv | 42 ++++
 rtl/l2_spi_slave_byte.sv | 203 ++++++++++++++++++++
 tb/tb_l2_spi_slave_byte.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_spi_pkg.sv
// Shared SPI definitions: mode encoding, link-FSM states and edge-select helper.
package l2_spi_pkg;

  // Mode encoding is {CPOL, CPHA}.
  localparam logic [1:0] SpiMode0 = 2'b00;
  localparam logic [1:0] SpiMode1 = 2'b01;
  localparam logic [1:0] SpiMode2 = 2'b10;
  localparam logic [1:0] SpiMode3 = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StActive
  } spi_state_e;

  // High when data is sampled on the rising SCLK edge.
  function automatic logic sample_on_rise(input logic cpol, input logic cpha);
    logic [1:0] mode;
    logic       rise;
    mode = {cpol, cpha};
    rise = 1'b0;
    case (mode)
      SpiMode0, SpiMode3: rise = 1'b1;
      SpiMode1, SpiMode2: rise = 1'b0;
      default:            rise = 1'b0;
    endcase
    return rise;
  endfunction

endpackage

// File: rtl/l2_spi_sync_edge.sv
// Synchronizer chain for one asynchronous pin with registered rise/fall strobes.
module l2_spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sig_i};
    prev_d = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
    fall_d = ~sync_q[SYNC_STAGES-1] & prev_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/l2_spi_slave_byte.sv
// SPI slave endpoint: oversampled SCLK/CS_N/MOSI, word shift in/out, TX holding register.
module l2_spi_slave_byte
  import l2_spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter logic        CPOL        = 1'b0,
  parameter logic        CPHA        = 1'b0,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        MSB_FIRST   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_sclk,
  input  logic                  i_cs_n,
  input  logic                  i_mosi,
  output logic                  o_miso,
  output logic                  o_miso_oe,
  input  logic [DATA_WIDTH-1:0] im_tx_data,
  input  logic                  im_tx_valid,
  output logic                  om_tx_ready,
  output logic [DATA_WIDTH-1:0] om_rx_data,
  output logic                  om_rx_valid,
  output logic                  om_sclk_rise,
  output logic                  om_sclk_fall,
  output logic                  om_busy,
  output logic                  om_tx_underrun
);

  localparam int unsigned CntW         = $clog2(DATA_WIDTH + 1);
  localparam logic        SampleOnRise = sample_on_rise(CPOL, CPHA);

  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
  endfunction

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic sample_stb, shift_stb, selected, abort, do_load, mosi_bit;
  logic [DATA_WIDTH-1:0] rx_next;

  spi_state_e            state_q, state_d;
  logic [SYNC_STAGES:0]  mosi_q, mosi_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  hold_valid_q, hold_valid_d;
  logic                  loaded_q, loaded_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  underrun_q, underrun_d;

  l2_spi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (CPOL)
  ) u_sync_sclk (
    .clk_i (clk),
    .rst_i (rst),
    .sig_i (i_sclk),
    .rise_o(sclk_rise),
    .fall_o(sclk_fall)
  );

  // Resetting the CS_N chain low means a select already held at reset release never
  // looks like a falling edge; the master must toggle CS_N to start a frame.
  l2_spi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (1'b0)
  ) u_sync_cs (
    .clk_i (clk),
    .rst_i (rst),
    .sig_i (i_cs_n),
    .rise_o(cs_rise),
    .fall_o(cs_fall)
  );

  // One extra MOSI stage matches the registered edge strobes.
  assign mosi_bit   = mosi_q[SYNC_STAGES];
  assign sample_stb = SampleOnRise ? sclk_rise : sclk_fall;
  assign shift_stb  = SampleOnRise ? sclk_fall : sclk_rise;
  assign selected   = (state_q != StIdle);
  assign abort      = selected & cs_rise;

  always_comb begin
    state_d      = state_q;
    mosi_d       = {mosi_q[SYNC_STAGES-1:0], i_mosi};
    tx_shift_d   = tx_shift_q;
    rx_shift_d   = rx_shift_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    rx_data_d    = rx_data_q;
    cnt_d        = cnt_q;
    loaded_d     = loaded_q;
    rx_valid_d   = 1'b0;
    underrun_d   = 1'b0;
    do_load      = 1'b0;
    rx_next      = MSB_FIRST ? {rx_shift_q[DATA_WIDTH-2:0], mosi_bit}
                             : {mosi_bit, rx_shift_q[DATA_WIDTH-1:1]};

    unique case (state_q)
      StIdle: begin
        if (cs_fall) state_d = StLoad;
      end
      StLoad: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          do_load = 1'b1;
          state_d = StActive;
        end
      end
      StActive: begin
        if (abort) begin
          state_d  = StIdle;
          cnt_d    = '0;
          loaded_d = 1'b0;
        end else if (sample_stb) begin
          rx_shift_d = rx_next;
          if (cnt_q == CntW'(DATA_WIDTH - 1)) begin
            rx_data_d  = rx_next;
            rx_valid_d = 1'b1;
            cnt_d      = '0;
            loaded_d   = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (shift_stb) begin
          // Counter at zero with no word loaded marks the start of a new word.
          if (cnt_q == '0 && !loaded_q) begin
            do_load = 1'b1;
          end else if (cnt_q != '0) begin
            tx_shift_d = MSB_FIRST ? (tx_shift_q << 1) : (tx_shift_q >> 1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (do_load) begin
      loaded_d = 1'b1;
      cnt_d    = '0;
      if (hold_valid_q) begin
        tx_shift_d   = hold_q;
        hold_valid_d = 1'b0;
      end else begin
        tx_shift_d = '0;
        underrun_d = 1'b1;
      end
    end

    // Write is judged on the registered flag, so a same-cycle load cannot see it.
    if (im_tx_valid && !hold_valid_q) begin
      hold_d       = im_tx_data;
      hold_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      mosi_q       <= '0;
      tx_shift_q   <= '0;
      rx_shift_q   <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      rx_data_q    <= '0;
      cnt_q        <= '0;
      loaded_q     <= 1'b0;
      rx_valid_q   <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      mosi_q       <= mosi_d;
      tx_shift_q   <= tx_shift_d;
      rx_shift_q   <= rx_shift_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      rx_data_q    <= rx_data_d;
      cnt_q        <= cnt_d;
      loaded_q     <= loaded_d;
      rx_valid_q   <= rx_valid_d;
      underrun_q   <= underrun_d;
    end
  end

  always_comb begin
    o_miso = 1'b0;
    if (state_q == StLoad) begin
      o_miso = hold_valid_q ? first_bit(hold_q) : 1'b0;
    end else if (state_q == StActive) begin
      o_miso = first_bit(tx_shift_q);
    end
  end

  assign o_miso_oe      = selected;
  assign om_busy        = selected;
  assign om_tx_ready    = ~hold_valid_q;
  assign om_rx_data     = rx_data_q;
  assign om_rx_valid    = rx_valid_q;
  assign om_tx_underrun = underrun_q;
  assign om_sclk_rise   = sclk_rise & selected;
  assign om_sclk_fall   = sclk_fall & selected;

endmodule

// File: tb/tb_l2_spi_slave_byte.sv
// Bench: SPI master model driving a mode-0 and a mode-3 slave, checked against expected words.
module tb_l2_spi_slave_byte;
  import l2_spi_pkg::*;

  localparam int W    = 8;
  localparam int S    = 2;
  localparam int HALF = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] sclk     = 2'b10;
  logic [1:0] cs_n     = 2'b11;
  logic [1:0] mosi     = 2'b00;
  logic [1:0] tx_valid = 2'b00;
  logic [1:0][W-1:0] tx_data = '0;
  logic [1:0] miso, miso_oe, tx_ready, rx_valid, srise, sfall, busy, underrun;
  logic [1:0][W-1:0] rx_data;

  int checks = 0;
  int errors = 0;
  int n_rx [2] = '{0, 0};
  int n_ur [2] = '{0, 0};
  int n_ri [2] = '{0, 0};
  int n_fa [2] = '{0, 0};
  int rd_ptr [2] = '{0, 0};
  logic [W-1:0] rx_log [2][64];

  always #5 clk = ~clk;

  l2_spi_slave_byte #(
    .DATA_WIDTH(W), .CPOL(SpiMode0[1]), .CPHA(SpiMode0[0]), .SYNC_STAGES(S), .MSB_FIRST(1'b1)
  ) u_dut_m0 (
    .clk(clk), .rst(rst), .i_sclk(sclk[0]), .i_cs_n(cs_n[0]), .i_mosi(mosi[0]),
    .o_miso(miso[0]), .o_miso_oe(miso_oe[0]), .im_tx_data(tx_data[0]),
    .im_tx_valid(tx_valid[0]), .om_tx_ready(tx_ready[0]), .om_rx_data(rx_data[0]),
    .om_rx_valid(rx_valid[0]), .om_sclk_rise(srise[0]), .om_sclk_fall(sfall[0]),
    .om_busy(busy[0]), .om_tx_underrun(underrun[0])
  );

  l2_spi_slave_byte #(
    .DATA_WIDTH(W), .CPOL(SpiMode3[1]), .CPHA(SpiMode3[0]), .SYNC_STAGES(S), .MSB_FIRST(1'b1)
  ) u_dut_m3 (
    .clk(clk), .rst(rst), .i_sclk(sclk[1]), .i_cs_n(cs_n[1]), .i_mosi(mosi[1]),
    .o_miso(miso[1]), .o_miso_oe(miso_oe[1]), .im_tx_data(tx_data[1]),
    .im_tx_valid(tx_valid[1]), .om_tx_ready(tx_ready[1]), .om_rx_data(rx_data[1]),
    .om_rx_valid(rx_valid[1]), .om_sclk_rise(srise[1]), .om_sclk_fall(sfall[1]),
    .om_busy(busy[1]), .om_tx_underrun(underrun[1])
  );

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (rx_valid[m]) begin
        if (n_rx[m] < 64) rx_log[m][n_rx[m]] <= rx_data[m];
        n_rx[m] <= n_rx[m] + 1;
      end
      if (underrun[m]) n_ur[m] <= n_ur[m] + 1;
      if (srise[m])    n_ri[m] <= n_ri[m] + 1;
      if (sfall[m])    n_fa[m] <= n_fa[m] + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_rx(input int u, input logic [W-1:0] exp);
    logic [W-1:0] got;
    got = 'x;
    if (rd_ptr[u] < n_rx[u]) got = rx_log[u][rd_ptr[u]];
    rd_ptr[u]++;
    check("rx_word", {24'd0, got}, {24'd0, exp});
  endtask

  task automatic put_tx(input int u, input logic [W-1:0] d);
    int n;
    n = 0;
    while (tx_ready[u] !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("tx_ready_wait", tx_ready[u], 1);
    tx_data[u]  = d;
    tx_valid[u] = 1'b1;
    @(negedge clk);
    tx_valid[u] = 1'b0;
    check("tx_ready_full", tx_ready[u], 0);
  endtask

  // Instance 0 is mode 0 (CPHA=0), instance 1 is mode 3 (CPHA=1); master is MSB first.
  task automatic xfer(input int u, input int nbits, input logic [15:0] tx,
                      output logic [15:0] rx);
    logic cpol;
    cpol = (u == 1);
    rx = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      if (u == 0) begin
        mosi[u] = tx[i];
        repeat (HALF) @(negedge clk);
        rx[i] = miso[u];
        sclk[u] = ~cpol;
        repeat (HALF) @(negedge clk);
        sclk[u] = cpol;
      end else begin
        sclk[u] = ~cpol;
        mosi[u] = tx[i];
        repeat (HALF) @(negedge clk);
        rx[i] = miso[u];
        sclk[u] = cpol;
        repeat (HALF) @(negedge clk);
      end
    end
  endtask

  task automatic frame_open(input int u);
    cs_n[u] = 1'b0;
    repeat (8) @(negedge clk);
    check("busy_open", busy[u], 1);
    check("oe_open", miso_oe[u], 1);
  endtask

  task automatic frame_close(input int u);
    repeat (HALF) @(negedge clk);
    cs_n[u] = 1'b1;
    repeat (8) @(negedge clk);
    check("busy_close", busy[u], 0);
    check("oe_close", miso_oe[u], 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] got;
    logic [W-1:0] d_rx, d_tx;
    int b_rx, b_ur, b_ri, b_fa, u;
    logic pre;

    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_miso", miso[i], 0);
      check("rst_oe", miso_oe[i], 0);
      check("rst_ready", tx_ready[i], 1);
      check("rst_rx_data", rx_data[i], 0);
      check("rst_rx_valid", rx_valid[i], 0);
      check("rst_busy", busy[i], 0);
      check("rst_underrun", underrun[i], 0);
      check("rst_rise", srise[i], 0);
      check("rst_fall", sfall[i], 0);
    end

    // 1: mode 0 single word
    put_tx(0, 8'h3C);
    b_rx = n_rx[0];
    frame_open(0);
    xfer(0, 8, 16'h00A5, got);
    frame_close(0);
    check("t1_miso", got, 16'h003C);
    check("t1_rx_count", n_rx[0] - b_rx, 1);
    expect_rx(0, 8'hA5);

    // 2: mode 3 single word with edge-strobe counts
    put_tx(1, 8'h81);
    b_rx = n_rx[1]; b_ri = n_ri[1]; b_fa = n_fa[1];
    frame_open(1);
    xfer(1, 8, 16'h007E, got);
    frame_close(1);
    check("t2_miso", got, 16'h0081);
    check("t2_rx_count", n_rx[1] - b_rx, 1);
    expect_rx(1, 8'h7E);
    check("t2_rise_count", n_ri[1] - b_ri, 8);
    check("t2_fall_count", n_fa[1] - b_fa, 8);

    // 3: back-to-back words in one frame (mode 3)
    put_tx(1, 8'h11);
    b_rx = n_rx[1]; b_ur = n_ur[1];
    frame_open(1);
    check("t3_ready_after_load", tx_ready[1], 1);
    put_tx(1, 8'h22);
    xfer(1, 16, 16'hDEAD, got);
    frame_close(1);
    check("t3_miso", got, 16'h1122);
    check("t3_rx_count", n_rx[1] - b_rx, 2);
    expect_rx(1, 8'hDE);
    expect_rx(1, 8'hAD);
    check("t3_underrun", n_ur[1] - b_ur, 0);

    // 4: underrun at frame start (mode 0)
    d_rx = W'($urandom);
    b_rx = n_rx[0]; b_ur = n_ur[0];
    frame_open(0);
    check("t4_underrun_at_load", n_ur[0] - b_ur, 1);
    xfer(0, 8, {8'h00, d_rx}, got);
    frame_close(0);
    check("t4_miso", got, 16'h0000);
    check("t4_rx_count", n_rx[0] - b_rx, 1);
    expect_rx(0, d_rx);

    // 5: abort after 5 bits, then a clean frame
    b_rx = n_rx[0];
    frame_open(0);
    xfer(0, 5, 16'h0015, got);
    cs_n[0] = 1'b1;
    repeat (S + 2) @(negedge clk);
    check("t5_oe_drop", miso_oe[0], 0);
    check("t5_miso_drop", miso[0], 0);
    repeat (8) @(negedge clk);
    check("t5_no_rx", n_rx[0] - b_rx, 0);
    put_tx(0, 8'h96);
    frame_open(0);
    xfer(0, 8, 16'h005A, got);
    frame_close(0);
    check("t5_miso", got, 16'h0096);
    check("t5_rx_count", n_rx[0] - b_rx, 1);
    expect_rx(0, 8'h5A);

    // 6: reset mid-frame; frame must not resume until CS_N toggles
    frame_open(0);
    put_tx(0, 8'h99);
    xfer(0, 3, 16'h0005, got);
    rst = 1'b1;
    @(negedge clk);
    check("t6_oe", miso_oe[0], 0);
    check("t6_miso", miso[0], 0);
    check("t6_ready", tx_ready[0], 1);
    check("t6_busy", busy[0], 0);
    check("t6_rx_data", rx_data[0], 0);
    rst = 1'b0;
    b_rx = n_rx[0]; b_ri = n_ri[0];
    xfer(0, 8, 16'h00FF, got);
    repeat (HALF) @(negedge clk);
    check("t6_no_rx", n_rx[0] - b_rx, 0);
    check("t6_no_rise", n_ri[0] - b_ri, 0);
    check("t6_still_idle", busy[0], 0);
    cs_n[0] = 1'b1;
    repeat (8) @(negedge clk);
    put_tx(0, 8'hE7);
    frame_open(0);
    xfer(0, 8, 16'h00C3, got);
    frame_close(0);
    check("t6_miso", got, 16'h00E7);
    check("t6_rx_count", n_rx[0] - b_rx, 1);
    expect_rx(0, 8'hC3);

    // Randomized single-word frames on either mode
    for (int k = 0; k < 8; k++) begin
      u    = int'($urandom_range(0, 1));
      d_rx = W'($urandom);
      d_tx = W'($urandom);
      pre  = 1'($urandom_range(0, 1));
      if (pre) put_tx(u, d_tx);
      b_rx = n_rx[u]; b_ur = n_ur[u];
      frame_open(u);
      xfer(u, 8, {8'h00, d_rx}, got);
      frame_close(u);
      check("rnd_miso", got, pre ? {8'h00, d_tx} : 16'h0000);
      check("rnd_rx_count", n_rx[u] - b_rx, 1);
      expect_rx(u, d_rx);
      if (u == 1) check("rnd_underrun_m3", n_ur[u] - b_ur, pre ? 0 : 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
